// File: rtl/k423_pkg.sv
// ----------------------------------------------------------------------------
// k423_pkg
// Shared types and constants for the k423 register-file write-port arbiter.
//   RSDIDX_W       : register index width (from `INST_RSDIDX_W, default 5)
//   XLEN           : integer datapath width (from `CORE_XLEN, default 32)
//   STARVE_MAX_DEF : default starvation limit for the LWB buffer
//   CNT_W          : width of the starvation counter (covers 1..15)
//   rf_wr_t        : one regfile write-port request {we, idx, data}
// ----------------------------------------------------------------------------
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

package k423_pkg;

    localparam int RSDIDX_W       = `INST_RSDIDX_W;
    localparam int XLEN           = `CORE_XLEN;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    typedef struct packed {
        logic                we;
        logic [RSDIDX_W-1:0] idx;
        logic [XLEN-1:0]     data;
    } rf_wr_t;

endpackage

// File: rtl/k423_rf_wr_buf.sv
// ----------------------------------------------------------------------------
// k423_rf_wr_buf
// One-entry valid/ready holding register for long-latency write-back results.
// Ready depends only on stored state and the drain input, so there is no
// combinational path from in_vld_i to in_rdy_o. Entries targeting x0 are
// accepted but dropped.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   in_vld_i/in_rdy_o     : input handshake
//   in_idx_i, in_data_i   : offered destination index and data
//   drain_i               : stored entry is consumed this cycle
//   buf_vld_o             : entry held
//   buf_idx_o, buf_data_o : stored index and data
// ----------------------------------------------------------------------------
module k423_rf_wr_buf
    import k423_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                in_vld_i,
    output logic                in_rdy_o,
    input  logic [RSDIDX_W-1:0] in_idx_i,
    input  logic [XLEN-1:0]     in_data_i,
    input  logic                drain_i,
    output logic                buf_vld_o,
    output logic [RSDIDX_W-1:0] buf_idx_o,
    output logic [XLEN-1:0]     buf_data_o
);

    logic                r_vld;
    logic [RSDIDX_W-1:0] r_idx;
    logic [XLEN-1:0]     r_data;
    logic                w_accept;

    // Refill in the same cycle the held entry drains.
    assign in_rdy_o = ~r_vld | drain_i;
    assign w_accept = in_vld_i & in_rdy_o;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // NOTE: data is reset as well so the held entry is fully cleared on reset.
            r_vld  <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            // An x0 entry loads as invalid: accepted, never written.
            r_vld  <= (in_idx_i != '0);
            r_idx  <= in_idx_i;
            r_data <= in_data_i;
        end else if (drain_i) begin
            r_vld  <= 1'b0;
        end
    end

    assign buf_vld_o  = r_vld;
    assign buf_idx_o  = r_idx;
    assign buf_data_o = r_data;

endmodule

// File: rtl/k423_rf_wr_arb.sv
// ----------------------------------------------------------------------------
// k423_rf_wr_arb
// Shares the single regfile write port between the in-order WB stage and the
// long-latency write-back source (LWB). LWB results wait in a one-entry
// buffer; WB has priority. With K423_RF_ARB_STARVE_EN defined, a buffered
// entry denied STARVE_MAX consecutive cycles is force-granted and WB stalls.
// Configuration macro: K423_RF_ARB_STARVE_EN (undefined = strict WB priority).
// Ports:
//   clk_i, rst_n_i                    : clock, synchronous active-low reset
//   wb_stage_vld_i, wb_rd_vld_i       : WB holds an instruction that writes rd
//   wb_rd_idx_i, wb_rd_i              : WB destination and data
//   wb_rdy_o                          : WB may retire this cycle
//   lwb_vld_i/lwb_rdy_o               : LWB result handshake
//   lwb_rd_idx_i, lwb_rd_i            : LWB destination and data
//   rf_we_o, rf_waddr_o, rf_wdata_o   : regfile write port
//   lwb_pend_o, lwb_pend_idx_o        : buffered LWB info for ID hazard logic
// ----------------------------------------------------------------------------
module k423_rf_wr_arb
    import k423_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wb_stage_vld_i,
    input  logic                wb_rd_vld_i,
    input  logic [RSDIDX_W-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]     wb_rd_i,
    output logic                wb_rdy_o,
    input  logic                lwb_vld_i,
    output logic                lwb_rdy_o,
    input  logic [RSDIDX_W-1:0] lwb_rd_idx_i,
    input  logic [XLEN-1:0]     lwb_rd_i,
    output logic                rf_we_o,
    output logic [RSDIDX_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]     rf_wdata_o,
    output logic                lwb_pend_o,
    output logic [RSDIDX_W-1:0] lwb_pend_idx_o
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("k423_rf_wr_arb: STARVE_MAX must be in 1..15");
    end

    logic                w_wb_req;
    logic                w_buf_vld;
    logic                w_buf_rdy;
    logic [RSDIDX_W-1:0] w_buf_idx;
    logic [XLEN-1:0]     w_buf_data;
    logic                w_force;
    logic                w_lwb_gnt;
    rf_wr_t              w_port;

    // Writes to x0 never occupy the port.
    assign w_wb_req = wb_stage_vld_i & wb_rd_vld_i & (wb_rd_idx_i != '0);

    k423_rf_wr_buf u_buf (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_vld_i   (lwb_vld_i),
        .in_rdy_o   (w_buf_rdy),
        .in_idx_i   (lwb_rd_idx_i),
        .in_data_i  (lwb_rd_i),
        .drain_i    (w_lwb_gnt),
        .buf_vld_o  (w_buf_vld),
        .buf_idx_o  (w_buf_idx),
        .buf_data_o (w_buf_data)
    );

`ifdef K423_RF_ARB_STARVE_EN
    logic [CNT_W-1:0] r_wait_cnt;

    // Counts consecutive denied cycles of the current entry, saturating.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wait_cnt <= '0;
        end else if (!w_buf_vld || w_lwb_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_W'(STARVE_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_force = w_buf_vld & (r_wait_cnt == CNT_W'(STARVE_MAX));
`else
    assign w_force = 1'b0;
`endif

    assign w_lwb_gnt = w_buf_vld & (~w_wb_req | w_force);

    // NOTE: defaults assigned first so every path drives w_port and no latch is inferred.
    always_comb begin
        w_port = '0;
        if (w_lwb_gnt) begin
            w_port = '{we: 1'b1, idx: w_buf_idx, data: w_buf_data};
        end else if (w_wb_req) begin
            w_port = '{we: 1'b1, idx: wb_rd_idx_i, data: wb_rd_i};
        end
    end

    // Reset holds the port idle and refuses new LWB results.
    assign rf_we_o        = rst_n_i & w_port.we;
    assign rf_waddr_o     = rst_n_i ? w_port.idx  : '0;
    assign rf_wdata_o     = rst_n_i ? w_port.data : '0;
    assign wb_rdy_o       = ~rst_n_i | ~(w_force & w_wb_req);
    assign lwb_rdy_o      = rst_n_i & w_buf_rdy;
    assign lwb_pend_o     = w_buf_vld;
    assign lwb_pend_idx_o = w_buf_vld ? w_buf_idx : '0;

    // ID must hold off any instruction whose rd matches the buffered entry.
    a_no_same_idx: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(w_wb_req && w_buf_vld && (wb_rd_idx_i == w_buf_idx)));

endmodule

// File: doc/k423_rf_wr_arb.md
# k423_rf_wr_arb

Register-file write-port arbiter for the k423 core. Shares the single integer register-file write port between the in-order WB stage and a long-latency write-back source (LWB: multi-cycle MDU/late load return). LWB results are held in a one-entry buffer. WB has priority, with optional starvation protection that stalls WB. Sits between WB stage outputs, the LWB unit and the regfile; exports pending-write info to the ID hazard logic.

## Interface
- STARVE_MAX, 4: max consecutive cycles a buffered LWB entry may be denied before forced grant; legal range 1..15
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; one clock, synchronous, active-low
- wb_stage_vld_i  in  1  WB stage holds a valid instruction
- wb_rd_vld_i  in  1  WB instruction writes rd
- wb_rd_idx_i  in  `INST_RSDIDX_W  WB destination index
- wb_rd_i  in  `CORE_XLEN  WB write data
- wb_rdy_o  out  1  WB may retire this cycle (feeds WB stage done)
- lwb_vld_i  in  1  LWB result offered
- lwb_rdy_o  out  1  LWB result accepted when high with lwb_vld_i
- lwb_rd_idx_i  in  `INST_RSDIDX_W  LWB destination index
- lwb_rd_i  in  `CORE_XLEN  LWB data
- rf_we_o  out  1  regfile write enable
- rf_waddr_o  out  `INST_RSDIDX_W  regfile write index
- rf_wdata_o  out  `CORE_XLEN  regfile write data
- lwb_pend_o  out  1  buffer holds an unwritten LWB result
- lwb_pend_idx_o  out  `INST_RSDIDX_W  index of buffered result (0 when empty)

## Operation
- wb_req = wb_stage_vld_i & wb_rd_vld_i & (wb_rd_idx_i != 0); writes to x0 never use the port.
- Buffer: buf_vld, buf_idx, buf_data. Accept = lwb_vld_i & lwb_rdy_o. Accepted entry with idx 0 is discarded (buf_vld stays/becomes 0 unless otherwise loaded).
- lwb_rdy_o = ~buf_vld | lwb_gnt (accept same cycle the buffer drains).
- Default grant: lwb_gnt = buf_vld & ~wb_req. WB granted whenever wb_req.
- Forced grant (starvation, see Configuration): force = buf_vld & (wait_cnt == STARVE_MAX); then lwb_gnt = 1 and WB is denied.
- wb_rdy_o = ~(force & wb_req). WB not needing the port is never stalled.
- Port mux: lwb_gnt -> {1, buf_idx, buf_data}; else wb_req -> {1, wb_rd_idx_i, wb_rd_i}; else rf_we_o = 0, addr/data = 0.
- wait_cnt: clears when ~buf_vld or lwb_gnt; increments when buf_vld & ~lwb_gnt; saturates at STARVE_MAX.
- Same-index ordering: ID must not issue an instruction whose rd equals lwb_pend_idx_o while lwb_pend_o; arbiter does not reorder. Simulation assertion: wb_req & buf_vld & (wb_rd_idx_i == buf_idx) never occurs.

## Timing
- Reset (rst_n_i low at clk edge): buf_vld=0, buf_idx=0, buf_data=0, wait_cnt=0. While rst_n_i low, rf_we_o=0, wb_rdy_o=1, lwb_rdy_o=0; resulting post-reset outputs: lwb_pend_o=0, lwb_pend_idx_o=0, rf_we_o follows wb_req.
- Reset mid-operation discards the buffered entry; no regfile write issued for it.
- WB path: zero latency, combinational to rf_* in the same cycle.
- LWB path: accepted at edge N, earliest regfile write in cycle N+1.
- Sustained throughput: one LWB per cycle when WB idle (drain and refill same cycle).
- Worst-case LWB wait with starvation enabled: STARVE_MAX cycles after entry, written in cycle STARVE_MAX+1.
- All outputs combinational from registered state plus current inputs; no combinational path from lwb_vld_i to lwb_rdy_o.

## Configuration
- K423_RF_ARB_STARVE_EN defined: wait_cnt and forced grant as above.
- Undefined: no wait_cnt; force=0; strict WB priority; wb_rdy_o tied 1; STARVE_MAX ignored. LWB may wait unboundedly.

## Structure
- k423_pkg: typedef rf_wr_t {we, idx[`INST_RSDIDX_W], data[`CORE_XLEN]}; localparam default STARVE_MAX.
- One sub-module: k423_rf_wr_buf (one-entry valid/ready holding register with drain input, x0 discard); arbitration and counter stay in top.

## Test plan
- WB only: wb_req idx=5 data=0x1234 every cycle -> rf_we_o=1, waddr=5, wdata=0x1234 same cycle, wb_rdy_o=1.
- LWB on idle WB: accept idx=7 data=0xBEEF at N -> rf write idx 7 at N+1; back-to-back idx 8,9 -> writes N+2, N+3, lwb_rdy_o held 1.
- Conflict, STARVE_MAX=4, starve enabled: buffer idx=3 with continuous wb_req -> WB granted 4 cycles, cycle 5 LWB written, wb_rdy_o=0 that cycle only, lwb_pend_o high for exactly 5 cycles.
- Same stimulus with K423_RF_ARB_STARVE_EN undefined -> LWB never written while wb_req held; written first cycle wb_req drops; wb_rdy_o never 0.
- x0 handling: wb_req idx=0 plus buffered idx=4 -> LWB granted; LWB idx=0 accepted -> no write, lwb_pend_o stays 0.
- Reset with buffered idx=6 pending -> next cycle lwb_pend_o=0, no write to x6, wait_cnt=0.
